// File: rtl/midi_pkg.sv
// Shared types for the MIDI voice allocator: event kinds, field widths and FSM states.
package midi_pkg;

  localparam int NOTE_W = 7;
  localparam int VEL_W  = 7;

  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_ON   = 2'd1,
    EV_OFF  = 2'd2
  } ev_kind_t;

  typedef struct packed {
    ev_kind_t            kind;
    logic [NOTE_W-1:0]   note;
    logic [VEL_W-1:0]    vel;
  } event_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/midi_voice_alloc_if.sv
// Parser-side event strobes and per-voice outputs towards the synthesis datapath.
interface midi_voice_alloc_if #(
  parameter int NUM_VOICES = 4
);
  logic                                   note_on;
  logic                                   note_off;
  logic                                   all_off;
  logic [midi_pkg::NOTE_W-1:0]            note;
  logic [midi_pkg::VEL_W-1:0]             velocity;
  logic [NUM_VOICES-1:0]                  voice_gate;
  logic [NUM_VOICES-1:0]                  voice_trig;
  logic [midi_pkg::NOTE_W*NUM_VOICES-1:0] voice_note;
  logic [midi_pkg::VEL_W*NUM_VOICES-1:0]  voice_vel;
  logic                                   busy;
  logic                                   drop;

  modport master (
    output note_on, note_off, all_off, note, velocity,
    input  voice_gate, voice_trig, voice_note, voice_vel, busy, drop
  );

  modport slave (
    input  note_on, note_off, all_off, note, velocity,
    output voice_gate, voice_trig, voice_note, voice_vel, busy, drop
  );
endinterface

// File: rtl/midi_voice_alloc_voice_slot.sv
// One voice slot: gate, note, velocity and a saturating age counter.
module voice_slot
  import midi_pkg::*;
#(
  parameter int AGE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic              rel,
  input  logic              age_inc,
  input  logic [NOTE_W-1:0] load_note,
  input  logic [VEL_W-1:0]  load_vel,
  output logic              gate,
  output logic [NOTE_W-1:0] note,
  output logic [VEL_W-1:0]  vel,
  output logic [AGE_W-1:0]  age
);

  // clear (all-notes-off) keeps note/velocity so release tails can still use them
  always_ff @(posedge clk) begin
    if (rst) begin
      gate <= 1'b0;
      note <= '0;
      vel  <= '0;
      age  <= '0;
    end else if (clear) begin
      gate <= 1'b0;
      age  <= '0;
    end else if (load) begin
      gate <= 1'b1;
      note <= load_note;
      vel  <= load_vel;
      age  <= '0;
    end else if (rel) begin
      gate <= 1'b0;
    end else if (age_inc && (age != '1)) begin
      age <= age + 1'b1;
    end
  end

endmodule

// File: rtl/midi_voice_alloc.sv
// Polyphonic voice allocator: one pending event slot, a voice-by-voice scan, and
// a commit that reuses a matching voice, takes a free one, or steals the oldest.
module midi_voice_alloc
  import midi_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int AGE_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  midi_voice_alloc_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_VOICES - 1);

  state_t state, state_nx;
  event_t pend, work;
  logic   pend_full;
  ev_kind_t in_kind;

  logic [IDX_W-1:0] idx;
  logic             hit_vld, hit_vld_nx, free_vld, free_vld_nx;
  logic [IDX_W-1:0] hit_idx, hit_nx, free_idx, free_nx, old_idx, old_nx, target;
  logic [AGE_W-1:0] old_age, old_age_nx;

  logic [NUM_VOICES-1:0] gate, load, rel, age_inc, trig;
  logic [NOTE_W-1:0]     slot_note [NUM_VOICES];
  logic [VEL_W-1:0]      slot_vel  [NUM_VOICES];
  logic [AGE_W-1:0]      slot_age  [NUM_VOICES];
  logic                  drop_r;

  // zero-velocity note-on and coincident on/off both collapse to a release
  always_comb begin
    in_kind = EV_NONE;
    if (bus.note_off || (bus.note_on && (bus.velocity == '0))) in_kind = EV_OFF;
    else if (bus.note_on)                                    in_kind = EV_ON;
  end

  // scan bookkeeping including the voice under examination this cycle
  always_comb begin
    hit_vld_nx = hit_vld;
    hit_nx     = hit_idx;
    free_vld_nx = free_vld;
    free_nx    = free_idx;
    old_nx     = old_idx;
    old_age_nx = old_age;
    if (!hit_vld && gate[idx] && (slot_note[idx] == work.note)) begin
      hit_vld_nx = 1'b1;
      hit_nx     = idx;
    end
    if (!free_vld && !gate[idx]) begin
      free_vld_nx = 1'b1;
      free_nx     = idx;
    end
    if ((idx == '0) || (slot_age[idx] > old_age)) begin
      old_nx     = idx;
      old_age_nx = slot_age[idx];
    end
  end

  always_comb begin
    target = old_nx;
    if (hit_vld_nx)       target = hit_nx;
    else if (free_vld_nx) target = free_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (pend_full) state_nx = ST_SCAN;
      ST_SCAN:   if (idx == LAST) state_nx = ST_COMMIT;
      ST_COMMIT: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
    if (bus.all_off) state_nx = ST_IDLE;
  end

  // the decision lands on the edge that finishes the last voice; COMMIT is the trig cycle
  always_comb begin
    load    = '0;
    rel     = '0;
    age_inc = '0;
    if ((state == ST_SCAN) && (idx == LAST) && !bus.all_off) begin
      if (work.kind == EV_ON) begin
        load[target] = 1'b1;
        age_inc      = gate & ~load;
      end else if ((work.kind == EV_OFF) && hit_vld_nx) begin
        rel[hit_nx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_full <= 1'b0;
      pend      <= '0;
      work      <= '0;
      idx       <= '0;
      hit_vld   <= 1'b0;
      hit_idx   <= '0;
      free_vld  <= 1'b0;
      free_idx  <= '0;
      old_idx   <= '0;
      old_age   <= '0;
      drop_r    <= 1'b0;
      trig      <= '0;
    end else begin
      drop_r <= 1'b0;
      trig   <= load;
      if (bus.all_off) begin
        pend_full <= 1'b0;
      end else begin
        if ((state == ST_IDLE) && pend_full) begin
          work      <= pend;
          pend_full <= 1'b0;
          idx       <= '0;
          hit_vld   <= 1'b0;
          free_vld  <= 1'b0;
        end else if ((in_kind != EV_NONE) && !pend_full) begin
          pend_full <= 1'b1;
          pend      <= '{kind: in_kind, note: bus.note, vel: bus.velocity};
        end
        if ((in_kind != EV_NONE) && pend_full) drop_r <= 1'b1;
        if (state == ST_SCAN) begin
          idx      <= idx + 1'b1;
          hit_vld  <= hit_vld_nx;
          hit_idx  <= hit_nx;
          free_vld <= free_vld_nx;
          free_idx <= free_nx;
          old_idx  <= old_nx;
          old_age  <= old_age_nx;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
    voice_slot #(.AGE_W(AGE_W)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .clear     (bus.all_off),
      .load      (load[i]),
      .rel       (rel[i]),
      .age_inc   (age_inc[i]),
      .load_note (work.note),
      .load_vel  (work.vel),
      .gate      (gate[i]),
      .note      (slot_note[i]),
      .vel       (slot_vel[i]),
      .age       (slot_age[i])
    );
    assign bus.voice_note[NOTE_W*i +: NOTE_W] = slot_note[i];
    assign bus.voice_vel[VEL_W*i +: VEL_W]    = slot_vel[i];
  end

  assign bus.voice_gate = gate;
  assign bus.voice_trig = trig;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.drop       = drop_r;

endmodule

// File: tb/tb_midi_voice_alloc.sv
// Directed bench for midi_voice_alloc with four voices and hand-computed expectations.
module tb_midi_voice_alloc;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  midi_voice_alloc_if #(.NUM_VOICES(4)) bus ();

  midi_voice_alloc #(.NUM_VOICES(4), .AGE_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [3:0] last_trig;

  function automatic logic [6:0] vnote(int i);
    return bus.voice_note[7*i +: 7];
  endfunction

  function automatic logic [6:0] vvel(int i);
    return bus.voice_vel[7*i +: 7];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic on, input logic off, input logic [6:0] n, input logic [6:0] v);
    bus.note_on  = on;
    bus.note_off = off;
    bus.note     = n;
    bus.velocity = v;
    tick();
    bus.note_on  = 1'b0;
    bus.note_off = 1'b0;
  endtask

  // strobe then wait until the allocator is idle again; last_trig holds the commit pulse
  task automatic ev(input logic on, input logic off, input logic [6:0] n, input logic [6:0] v);
    drive(on, off, n, v);
    repeat (5) tick();
    last_trig = bus.voice_trig;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.voice_gate !== 4'b0000) begin errors++; $display("FAIL reset_gate got %b expected 0000", bus.voice_gate); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", bus.busy); end
    checks++; if (bus.voice_trig !== 4'b0000) begin errors++; $display("FAIL reset_trig got %b expected 0000", bus.voice_trig); end
    checks++; if (bus.drop !== 1'b0) begin errors++; $display("FAIL reset_drop got %b expected 0", bus.drop); end
    checks++; if (bus.voice_note !== 28'd0 || bus.voice_vel !== 28'd0) begin errors++; $display("FAIL reset_note_vel got %h/%h expected 0/0", bus.voice_note, bus.voice_vel); end
  endtask

  task automatic test_first_note();
    do_reset();
    drive(1'b1, 1'b0, 7'd60, 7'd100);
    tick();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL first_busy_e1 got %b expected 1", bus.busy); end
    repeat (3) tick();
    checks++; if (bus.voice_gate !== 4'b0000 || bus.voice_trig !== 4'b0000) begin errors++; $display("FAIL first_early_e4 got gate %b trig %b expected 0000 0000", bus.voice_gate, bus.voice_trig); end
    tick();
    checks++; if (bus.voice_gate !== 4'b0001) begin errors++; $display("FAIL first_gate_e5 got %b expected 0001", bus.voice_gate); end
    checks++; if (bus.voice_trig !== 4'b0001) begin errors++; $display("FAIL first_trig_e5 got %b expected 0001", bus.voice_trig); end
    checks++; if (vnote(0) !== 7'd60 || vvel(0) !== 7'd100) begin errors++; $display("FAIL first_note_vel got %0d/%0d expected 60/100", vnote(0), vvel(0)); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL first_busy_commit got %b expected 1", bus.busy); end
    tick();
    checks++; if (bus.voice_trig !== 4'b0000 || bus.busy !== 1'b0) begin errors++; $display("FAIL first_after_commit got trig %b busy %b expected 0000 0", bus.voice_trig, bus.busy); end
  endtask

  task automatic test_fill_release();
    do_reset();
    ev(1'b1, 1'b0, 7'd60, 7'd100);
    ev(1'b1, 1'b0, 7'd62, 7'd100);
    ev(1'b1, 1'b0, 7'd64, 7'd100);
    ev(1'b1, 1'b0, 7'd67, 7'd100);
    checks++; if (bus.voice_gate !== 4'b1111) begin errors++; $display("FAIL fill_gate got %b expected 1111", bus.voice_gate); end
    checks++; if (bus.voice_note !== {7'd67, 7'd64, 7'd62, 7'd60}) begin errors++; $display("FAIL fill_notes got %h expected %h", bus.voice_note, {7'd67, 7'd64, 7'd62, 7'd60}); end
    ev(1'b0, 1'b1, 7'd62, 7'd0);
    checks++; if (bus.voice_gate !== 4'b1101) begin errors++; $display("FAIL release_gate got %b expected 1101", bus.voice_gate); end
    checks++; if (vnote(1) !== 7'd62) begin errors++; $display("FAIL release_note_held got %0d expected 62", vnote(1)); end
    ev(1'b1, 1'b0, 7'd72, 7'd90);
    checks++; if (bus.voice_gate !== 4'b1111 || vnote(1) !== 7'd72) begin errors++; $display("FAIL reuse_voice1 got gate %b note %0d expected 1111 72", bus.voice_gate, vnote(1)); end
    checks++; if (last_trig !== 4'b0010) begin errors++; $display("FAIL reuse_trig got %b expected 0010", last_trig); end
  endtask

  task automatic test_steal();
    do_reset();
    ev(1'b1, 1'b0, 7'd60, 7'd100);
    ev(1'b1, 1'b0, 7'd62, 7'd100);
    ev(1'b1, 1'b0, 7'd64, 7'd100);
    ev(1'b1, 1'b0, 7'd67, 7'd100);
    ev(1'b1, 1'b0, 7'd70, 7'd33);
    checks++; if (bus.voice_note !== {7'd67, 7'd64, 7'd62, 7'd70}) begin errors++; $display("FAIL steal_notes got %h expected %h", bus.voice_note, {7'd67, 7'd64, 7'd62, 7'd70}); end
    checks++; if (last_trig !== 4'b0001 || vvel(0) !== 7'd33) begin errors++; $display("FAIL steal_trig_vel got %b/%0d expected 0001/33", last_trig, vvel(0)); end
    checks++; if (bus.voice_gate !== 4'b1111) begin errors++; $display("FAIL steal_gate got %b expected 1111", bus.voice_gate); end
    // voice1 (62) is now the oldest
    ev(1'b1, 1'b0, 7'd71, 7'd40);
    checks++; if (vnote(1) !== 7'd71 || last_trig !== 4'b0010) begin errors++; $display("FAIL steal_second got note %0d trig %b expected 71 0010", vnote(1), last_trig); end
  endtask

  task automatic test_retrigger();
    do_reset();
    ev(1'b1, 1'b0, 7'd60, 7'd100);
    ev(1'b1, 1'b0, 7'd60, 7'd50);
    checks++; if (bus.voice_gate !== 4'b0001 || vvel(0) !== 7'd50) begin errors++; $display("FAIL retrig_same got gate %b vel %0d expected 0001 50", bus.voice_gate, vvel(0)); end
    checks++; if (last_trig !== 4'b0001) begin errors++; $display("FAIL retrig_trig got %b expected 0001", last_trig); end
    ev(1'b1, 1'b0, 7'd60, 7'd0);
    checks++; if (bus.voice_gate !== 4'b0000 || vnote(0) !== 7'd60) begin errors++; $display("FAIL vel0_off got gate %b note %0d expected 0000 60", bus.voice_gate, vnote(0)); end
    ev(1'b1, 1'b0, 7'd62, 7'd80);
    ev(1'b1, 1'b1, 7'd62, 7'd80);
    checks++; if (bus.voice_gate !== 4'b0000 || last_trig !== 4'b0000) begin errors++; $display("FAIL on_off_same_cycle got gate %b trig %b expected 0000 0000", bus.voice_gate, last_trig); end
    ev(1'b0, 1'b1, 7'd99, 7'd0);
    checks++; if (bus.voice_gate !== 4'b0000 || vnote(0) !== 7'd62) begin errors++; $display("FAIL off_no_hit got gate %b note %0d expected 0000 62", bus.voice_gate, vnote(0)); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1'b1, 1'b0, 7'd60, 7'd100);
    tick();
    drive(1'b1, 1'b0, 7'd62, 7'd90);
    checks++; if (bus.drop !== 1'b0) begin errors++; $display("FAIL b2b_second_accepted got drop %b expected 0", bus.drop); end
    tick();
    drive(1'b1, 1'b0, 7'd64, 7'd80);
    checks++; if (bus.drop !== 1'b1) begin errors++; $display("FAIL b2b_third_drop got %b expected 1", bus.drop); end
    tick();
    checks++; if (bus.drop !== 1'b0) begin errors++; $display("FAIL b2b_drop_one_cycle got %b expected 0", bus.drop); end
    checks++; if (bus.voice_trig !== 4'b0001) begin errors++; $display("FAIL b2b_first_trig got %b expected 0001", bus.voice_trig); end
    repeat (6) tick();
    checks++; if (bus.voice_trig !== 4'b0010 || vnote(1) !== 7'd62) begin errors++; $display("FAIL b2b_second_trig got %b note %0d expected 0010 62", bus.voice_trig, vnote(1)); end
    repeat (3) tick();
    checks++; if (bus.voice_gate !== 4'b0011 || bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_final got gate %b busy %b expected 0011 0", bus.voice_gate, bus.busy); end
  endtask

  task automatic test_all_off();
    logic [3:0] trig_seen;
    logic       busy_seen;
    do_reset();
    ev(1'b1, 1'b0, 7'd60, 7'd100);
    ev(1'b1, 1'b0, 7'd62, 7'd100);
    drive(1'b1, 1'b0, 7'd64, 7'd70);
    tick();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL alloff_midscan_busy got %b expected 1", bus.busy); end
    bus.all_off = 1'b1;
    tick();
    bus.all_off = 1'b0;
    checks++; if (bus.voice_gate !== 4'b0000 || bus.busy !== 1'b0) begin errors++; $display("FAIL alloff_clear got gate %b busy %b expected 0000 0", bus.voice_gate, bus.busy); end
    trig_seen = bus.voice_trig;
    busy_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      trig_seen = trig_seen | bus.voice_trig;
      busy_seen = busy_seen | bus.busy;
    end
    checks++; if (trig_seen !== 4'b0000 || busy_seen !== 1'b0 || bus.voice_gate !== 4'b0000) begin errors++; $display("FAIL alloff_quiet got trig %b busy %b gate %b expected 0000 0 0000", trig_seen, busy_seen, bus.voice_gate); end
    checks++; if (vnote(0) !== 7'd60 || vnote(1) !== 7'd62) begin errors++; $display("FAIL alloff_notes_held got %0d/%0d expected 60/62", vnote(0), vnote(1)); end
    // coincident strobe is discarded along with everything else
    bus.all_off = 1'b1;
    drive(1'b1, 1'b0, 7'd66, 7'd10);
    bus.all_off = 1'b0;
    repeat (6) tick();
    checks++; if (bus.voice_gate !== 4'b0000 || bus.drop !== 1'b0) begin errors++; $display("FAIL alloff_coincident got gate %b drop %b expected 0000 0", bus.voice_gate, bus.drop); end
    ev(1'b1, 1'b0, 7'd65, 7'd20);
    checks++; if (bus.voice_gate !== 4'b0001 || vnote(0) !== 7'd65) begin errors++; $display("FAIL alloff_reuse got gate %b note %0d expected 0001 65", bus.voice_gate, vnote(0)); end
  endtask

  task automatic test_reset_midscan();
    do_reset();
    drive(1'b1, 1'b0, 7'd60, 7'd100);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (6) tick();
    checks++; if (bus.voice_gate !== 4'b0000 || bus.busy !== 1'b0 || vnote(0) !== 7'd0) begin errors++; $display("FAIL rst_midscan got gate %b busy %b note %0d expected 0000 0 0", bus.voice_gate, bus.busy, vnote(0)); end
  endtask

  initial begin
    rst          = 1'b1;
    bus.note_on  = 1'b0;
    bus.note_off = 1'b0;
    bus.all_off  = 1'b0;
    bus.note     = '0;
    bus.velocity = '0;
    test_reset();
    test_first_note();
    test_fill_release();
    test_steal();
    test_retrigger();
    test_back_to_back();
    test_all_off();
    test_reset_midscan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/midi_voice_alloc.md
# midi_voice_alloc

Polyphonic voice allocator between the MIDI command parser and the bank of voice oscillators/envelopes. Consumes one-cycle note-press/note-release/reset pulses with note and velocity, and assigns each note to one of `NUM_VOICES` voice slots. Steals the oldest voice when all slots are busy. Drives per-voice note, velocity, gate and a retrigger strobe to the synthesis datapath.

## Interface
- `NUM_VOICES`, 4: number of voice slots, 2..16.
- `AGE_W`, 8: width of per-voice age counters (saturating).

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `note_on`  in  1  one-cycle note-press strobe.
- `note_off`  in  1  one-cycle note-release strobe.
- `all_off`  in  1  one-cycle all-notes-off strobe, from the parser reset command.
- `note`  in  7  MIDI note number, valid with a strobe.
- `velocity`  in  7  MIDI velocity, valid with a strobe.
- `voice_gate`  out  NUM_VOICES  voice i is held by a note.
- `voice_trig`  out  NUM_VOICES  one-cycle pulse when voice i is (re)assigned.
- `voice_note`  out  7*NUM_VOICES  note of voice i in bits [7i+6:7i].
- `voice_vel`  out  7*NUM_VOICES  velocity of voice i, same packing.
- `busy`  out  1  FSM not in IDLE.
- `drop`  out  1  one-cycle pulse when an event is lost.

## Operation
- Event decode:
  - `note_on` with `velocity==0` is treated as note-off.
  - If `note_on` and `note_off` arrive in the same cycle, the event is treated as note-off.
- Pending slot: one entry holding kind, note and velocity.
  - A strobe is written into the slot when the slot is empty.
  - A strobe arriving while the slot is full is discarded and `drop` pulses for one cycle.
- FSM states: IDLE, SCAN, COMMIT.
  - IDLE → SCAN when the pending slot is full. The slot is moved to the working register, the slot is freed, and `idx=0`.
  - SCAN: examines voice `idx` each cycle, then `idx++`. After `idx==NUM_VOICES-1` the FSM goes to COMMIT.
  - COMMIT: applies the decision, then returns to IDLE.
- Scan bookkeeping, per voice:
  - Records the first gated voice whose note matches (`hit`).
  - Records the lowest-index free voice (`free`).
  - Records the voice with the maximum age, ties going to the lowest index (`old`).
- Note-on commit, first rule that applies:
  - `hit` exists → that voice gets the new velocity.
  - else `free` exists → that voice.
  - else `old` → steal that voice.
  - The chosen voice gets gate=1, note and velocity loaded, trig=1, age=0. Every other gated voice increments its age, saturating at 2^AGE_W-1.
- Note-off commit:
  - If `hit` exists, that voice's gate is cleared. Note and velocity are held. Age is unchanged.
  - If there is no `hit`, nothing changes. This is not an error.
- `all_off` has priority over everything:
  - On the next edge, all gates, ages, the pending slot and the FSM are cleared (FSM returns to IDLE).
  - Note and velocity registers are held.
  - An `all_off` coincident with a note strobe discards the note strobe.
- Reset values: gates 0, trig 0, notes 0, velocities 0, ages 0, `busy` 0, `drop` 0, pending slot empty, FSM IDLE.

## Timing
- Strobe sampled at edge E0 → working register loaded at E1 (IDLE→SCAN).
- SCAN occupies E1..E(NUM_VOICES), then COMMIT.
- Outputs update at edge E(NUM_VOICES+1) (edges counted from E0). With `NUM_VOICES=4` that is 5 clocks after the strobe edge.
- `voice_trig` is high for exactly one cycle after the COMMIT edge.
- `busy` is high from E1 through the COMMIT cycle.
- Back-to-back: a pending event enters SCAN the cycle after COMMIT, giving a throughput of one event per NUM_VOICES+2 cycles. This is far above the MIDI byte rate, so `drop` fires only under test stress.
- `rst` mid-scan aborts the scan with no partial update.

## Structure
- Shared package `midi_pkg`:
  - event kind enum (NONE, ON, OFF);
  - `NOTE_W=7`, `VEL_W=7`;
  - FSM state enum.
- One natural sub-module, `voice_slot`:
  - holds gate, note, velocity and age for one voice;
  - has load/release/age-increment/clear controls.
  - It is instantiated NUM_VOICES times.
- The allocator keeps the FSM, the pending slot and the scan comparators.

## Test plan
- Reset → all gates 0, `busy` 0. Then note_on(60,100) → voice0 gate=1, note=60, vel=100, trig pulse on bit0 only, 5 clocks after the strobe.
- note_on 60, 62, 64, 67 → voices 0..3 in that order. Then note_off(62) → only voice1 gate drops. Then note_on(72) → voice1 reused.
- Four voices held (60, 62, 64, 67 in that order), then note_on(70) → voice0 (oldest, note 60) stolen: note=70, trig bit0.
- note_on(60,100) then note_on(60,50) → same voice, vel=50, retrigger pulse, no second voice used. Then note_on(60,0) → gate cleared.
- Three strobes spaced one cycle apart while busy → first two processed, third discarded with `drop`=1 for one cycle.
- `all_off` asserted mid-SCAN with voices gated → all gates 0 next edge, FSM IDLE, pending slot empty, no trig.
